// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - instruction queue that decodes MIPS words into order codes at push time
module instr_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ORDER_W-1:0]         out_order,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic                       out_ri,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ORDER_W-1:0] ORD_NOP   = ORDER_W'(0);
  localparam logic [ORDER_W-1:0] ORD_SLL   = ORDER_W'(1);
  localparam logic [ORDER_W-1:0] ORD_SRL   = ORDER_W'(2);
  localparam logic [ORDER_W-1:0] ORD_SRA   = ORDER_W'(3);
  localparam logic [ORDER_W-1:0] ORD_SLLV  = ORDER_W'(4);
  localparam logic [ORDER_W-1:0] ORD_SRLV  = ORDER_W'(5);
  localparam logic [ORDER_W-1:0] ORD_SRAV  = ORDER_W'(6);
  localparam logic [ORDER_W-1:0] ORD_JR    = ORDER_W'(7);
  localparam logic [ORDER_W-1:0] ORD_JALR  = ORDER_W'(8);
  localparam logic [ORDER_W-1:0] ORD_MFHI  = ORDER_W'(9);
  localparam logic [ORDER_W-1:0] ORD_MTHI  = ORDER_W'(10);
  localparam logic [ORDER_W-1:0] ORD_MFLO  = ORDER_W'(11);
  localparam logic [ORDER_W-1:0] ORD_MTLO  = ORDER_W'(12);
  localparam logic [ORDER_W-1:0] ORD_MULT  = ORDER_W'(13);
  localparam logic [ORDER_W-1:0] ORD_MULTU = ORDER_W'(14);
  localparam logic [ORDER_W-1:0] ORD_DIV   = ORDER_W'(15);
  localparam logic [ORDER_W-1:0] ORD_DIVU  = ORDER_W'(16);
  localparam logic [ORDER_W-1:0] ORD_ADD   = ORDER_W'(17);
  localparam logic [ORDER_W-1:0] ORD_ADDU  = ORDER_W'(18);
  localparam logic [ORDER_W-1:0] ORD_SUB   = ORDER_W'(19);
  localparam logic [ORDER_W-1:0] ORD_SUBU  = ORDER_W'(20);
  localparam logic [ORDER_W-1:0] ORD_AND   = ORDER_W'(21);
  localparam logic [ORDER_W-1:0] ORD_OR    = ORDER_W'(22);
  localparam logic [ORDER_W-1:0] ORD_XOR   = ORDER_W'(23);
  localparam logic [ORDER_W-1:0] ORD_NOR   = ORDER_W'(24);
  localparam logic [ORDER_W-1:0] ORD_SLT   = ORDER_W'(25);
  localparam logic [ORDER_W-1:0] ORD_SLTU  = ORDER_W'(26);
  localparam logic [ORDER_W-1:0] ORD_BLTZ  = ORDER_W'(27);
  localparam logic [ORDER_W-1:0] ORD_BGEZ  = ORDER_W'(28);
  localparam logic [ORDER_W-1:0] ORD_J     = ORDER_W'(29);
  localparam logic [ORDER_W-1:0] ORD_JAL   = ORDER_W'(30);
  localparam logic [ORDER_W-1:0] ORD_BEQ   = ORDER_W'(31);
  localparam logic [ORDER_W-1:0] ORD_BNE   = ORDER_W'(32);
  localparam logic [ORDER_W-1:0] ORD_BLEZ  = ORDER_W'(33);
  localparam logic [ORDER_W-1:0] ORD_BGTZ  = ORDER_W'(34);
  localparam logic [ORDER_W-1:0] ORD_ADDI  = ORDER_W'(35);
  localparam logic [ORDER_W-1:0] ORD_ADDIU = ORDER_W'(36);
  localparam logic [ORDER_W-1:0] ORD_SLTI  = ORDER_W'(37);
  localparam logic [ORDER_W-1:0] ORD_SLTIU = ORDER_W'(38);
  localparam logic [ORDER_W-1:0] ORD_ANDI  = ORDER_W'(39);
  localparam logic [ORDER_W-1:0] ORD_ORI   = ORDER_W'(40);
  localparam logic [ORDER_W-1:0] ORD_XORI  = ORDER_W'(41);
  localparam logic [ORDER_W-1:0] ORD_LUI   = ORDER_W'(42);
  localparam logic [ORDER_W-1:0] ORD_LB    = ORDER_W'(43);
  localparam logic [ORDER_W-1:0] ORD_LH    = ORDER_W'(44);
  localparam logic [ORDER_W-1:0] ORD_LW    = ORDER_W'(45);
  localparam logic [ORDER_W-1:0] ORD_LBU   = ORDER_W'(46);
  localparam logic [ORDER_W-1:0] ORD_LHU   = ORDER_W'(47);
  localparam logic [ORDER_W-1:0] ORD_SB    = ORDER_W'(48);
  localparam logic [ORDER_W-1:0] ORD_SH    = ORDER_W'(49);
  localparam logic [ORDER_W-1:0] ORD_SW    = ORDER_W'(50);

  logic [ORDER_W-1:0] mem_order [DEPTH];
  logic               mem_ri    [DEPTH];
  logic [31:0]        mem_instr [DEPTH];
  logic [31:0]        mem_pc    [DEPTH];

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               push;
  logic               pop;
  logic [ORDER_W-1:0] dec_order;
  logic               dec_ri;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         rt;

  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign rt     = in_instr[20:16];

  always_comb begin
    dec_order = ORD_NOP;
    dec_ri    = 1'b0;
    case (opcode)
      6'd0: begin
        case (funct)
          6'd0:  dec_order = ORD_SLL;
          6'd2:  dec_order = ORD_SRL;
          6'd3:  dec_order = ORD_SRA;
          6'd4:  dec_order = ORD_SLLV;
          6'd6:  dec_order = ORD_SRLV;
          6'd7:  dec_order = ORD_SRAV;
          6'd8:  dec_order = ORD_JR;
          6'd9:  dec_order = ORD_JALR;
          6'd16: dec_order = ORD_MFHI;
          6'd17: dec_order = ORD_MTHI;
          6'd18: dec_order = ORD_MFLO;
          6'd19: dec_order = ORD_MTLO;
          6'd24: dec_order = ORD_MULT;
          6'd25: dec_order = ORD_MULTU;
          6'd26: dec_order = ORD_DIV;
          6'd27: dec_order = ORD_DIVU;
          6'd32: dec_order = ORD_ADD;
          6'd33: dec_order = ORD_ADDU;
          6'd34: dec_order = ORD_SUB;
          6'd35: dec_order = ORD_SUBU;
          6'd36: dec_order = ORD_AND;
          6'd37: dec_order = ORD_OR;
          6'd38: dec_order = ORD_XOR;
          6'd39: dec_order = ORD_NOR;
          6'd42: dec_order = ORD_SLT;
          6'd43: dec_order = ORD_SLTU;
          default: dec_ri = 1'b1;
        endcase
      end
      6'd1: begin
        case (rt)
          5'd0:  dec_order = ORD_BLTZ;
          5'd1:  dec_order = ORD_BGEZ;
          default: dec_ri = 1'b1;
        endcase
      end
      6'd2:  dec_order = ORD_J;
      6'd3:  dec_order = ORD_JAL;
      6'd4:  dec_order = ORD_BEQ;
      6'd5:  dec_order = ORD_BNE;
      6'd6:  dec_order = ORD_BLEZ;
      6'd7:  dec_order = ORD_BGTZ;
      6'd8:  dec_order = ORD_ADDI;
      6'd9:  dec_order = ORD_ADDIU;
      6'd10: dec_order = ORD_SLTI;
      6'd11: dec_order = ORD_SLTIU;
      6'd12: dec_order = ORD_ANDI;
      6'd13: dec_order = ORD_ORI;
      6'd14: dec_order = ORD_XORI;
      6'd15: dec_order = ORD_LUI;
      6'd32: dec_order = ORD_LB;
      6'd33: dec_order = ORD_LH;
      6'd35: dec_order = ORD_LW;
      6'd36: dec_order = ORD_LBU;
      6'd37: dec_order = ORD_LHU;
      6'd40: dec_order = ORD_SB;
      6'd41: dec_order = ORD_SH;
      6'd43: dec_order = ORD_SW;
      default: dec_ri = 1'b1;
    endcase
  end

  // in_ready depends on occupancy only, so a full queue never accepts even while popping
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is never cleared; only occupancy state is reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_order[wr_ptr] <= dec_order;
      mem_ri[wr_ptr]    <= dec_ri;
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  assign out_order = reset ? mem_order[rd_ptr] : ORD_NOP;
  assign out_ri    = reset ? mem_ri[rd_ptr]    : 1'b0;
  assign out_instr = reset ? mem_instr[rd_ptr] : 32'd0;
  assign out_pc    = reset ? mem_pc[rd_ptr]    : 32'd0;

endmodule
